// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
//   Bundles the instruction-fetch signals: the instruction memory
//   req/gnt/rvalid bus, the controller redirect, and the decode-side
//   holding buffer.
//   master : the fetch unit (drives imem_req/addr, if_* outputs)
//   slave  : the environment (memory, controller and decode stage)
// Signals:
//   imem_req, imem_addr[31:0]          fetch -> memory request
//   imem_gnt, imem_rvalid, imem_rdata  memory -> fetch
//   redirect, redirect_target[31:0]    controller -> fetch
//   if_valid, if_instr, if_pc,
//   if_pc_plus4, opcode, funct3,
//   funct7b5                           fetch -> decode
//   if_ready                           decode -> fetch
// ---------------------------------------------------------------------------
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_target,
    output if_valid, if_instr, if_pc, if_pc_plus4, opcode, funct3, funct7b5,
    input  if_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_target,
    input  if_valid, if_instr, if_pc, if_pc_plus4, opcode, funct3, funct7b5,
    output if_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   RV32I instruction fetch front end. Owns the PC, issues one word read at
//   a time to instruction memory, holds one fetched instruction for decode
//   and steers the next fetch on a controller redirect.
// Ports:
//   clk    clock, all state on rising edge
//   rst_n  asynchronous active-low reset
//   bus    instr_fetch_if.master (memory bus, redirect, decode buffer)
// Parameters:
//   RESET_PC   first PC fetched after reset release
//   NOP_INSTR  if_instr value while no instruction is held
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no request; wait until the buffer is empty or draining
// REQ    | imem_req=1 with imem_addr=pc, held until gnt
// WAIT   | one request outstanding; kill set means drop its response
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst_n,
  instr_fetch_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic        r_kill;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_if_pc;

  logic        w_consume;
  logic        w_room;
  logic [31:0] w_target;

  assign w_consume = r_valid & bus.if_ready;
  // A new request may start only if the buffer will be free to take it.
  assign w_room    = ~r_valid | w_consume;
  assign w_target  = bus.redirect_target & ~32'h3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= {RESET_PC[31:2], 2'b00};
      r_kill  <= 1'b0;
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_if_pc <= RESET_PC;
    end else begin
      if (w_consume) begin
        r_valid <= 1'b0;
        r_instr <= NOP_INSTR;
      end
      if (bus.redirect) begin
        r_pc    <= w_target;
        r_valid <= 1'b0;
        r_instr <= NOP_INSTR;
        case (r_state)
          S_IDLE: begin
            r_state <= S_REQ;
            r_kill  <= 1'b0;
          end
          S_REQ: begin
            // A grant in the redirect cycle still yields a response, which
            // must be swallowed.
            if (bus.imem_gnt) begin
              r_state <= S_WAIT;
              r_kill  <= 1'b1;
            end else begin
              r_state <= S_REQ;
            end
          end
          S_WAIT: begin
            if (bus.imem_rvalid) begin
              r_state <= S_REQ;
              r_kill  <= 1'b0;
            end else begin
              r_kill  <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_kill  <= 1'b0;
          end
        endcase
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_room) r_state <= S_REQ;
          end
          S_REQ: begin
            if (bus.imem_gnt) r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (bus.imem_rvalid) begin
              if (r_kill) begin
                r_kill  <= 1'b0;
                r_state <= S_REQ;
              end else begin
                r_instr <= bus.imem_rdata;
                r_if_pc <= r_pc;
                r_valid <= 1'b1;
                r_pc    <= r_pc + 32'd4;
                r_state <= S_IDLE;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.imem_req    = (r_state == S_REQ);
  assign bus.imem_addr   = r_pc;
  assign bus.if_valid    = r_valid;
  assign bus.if_instr    = r_instr;
  assign bus.if_pc       = r_if_pc;
  assign bus.if_pc_plus4 = r_if_pc + 32'd4;
  assign bus.opcode      = r_instr[6:0];
  assign bus.funct3      = r_instr[14:12];
  assign bus.funct7b5    = r_instr[30];

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//   Scoreboard bench for instr_fetch. Stimulus pushes the expected
//   {pc, instr} of every instruction decode should see; a monitor pops and
//   compares whenever if_valid & if_ready. A second instance with
//   RESET_PC = FFFF_FFFC checks PC wrap.
// ---------------------------------------------------------------------------
module tb_instr_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_if bus_a ();
  instr_fetch_if bus_b ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.master));
  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.master));

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  // Memory contents: word 0 is addi x1,x0,5, others a recognisable pattern.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0], 16'h0000} ^ 32'h4000_5033;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    chk32(name, {31'b0, act}, {31'b0, req});
  endtask

  task automatic push(input logic [31:0] p);
    sb.push_back('{pc: p, instr: memf(p)});
  endtask

  task automatic wait_valid(input string name, input int bound);
    int n = 0;
    while (!bus_a.if_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus_a.if_valid) begin
      failures++;
      $display("FAIL %s timeout actual=if_valid 0 required=if_valid 1", name);
    end
  endtask

  task automatic wait_req(input string name, input int bound);
    int n = 0;
    while (!bus_a.imem_req && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus_a.imem_req) begin
      failures++;
      $display("FAIL %s timeout actual=imem_req 0 required=imem_req 1", name);
    end
  endtask

  // ---------------- memory responder for dut_a ----------------
  int          lat    = 1;
  logic        gnt_en = 1'b1;
  logic        fire_prev = 1'b0;
  logic [31:0] addr_prev = 32'h0;
  logic        out_v = 1'b0;
  logic [31:0] out_addr = 32'h0;
  int          out_cnt = 0;

  initial begin
    bus_a.imem_gnt    = 1'b0;
    bus_a.imem_rvalid = 1'b0;
    bus_a.imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (fire_prev) begin
        out_v    = 1'b1;
        out_addr = addr_prev;
        out_cnt  = lat;
      end
      bus_a.imem_rvalid = 1'b0;
      if (out_v) begin
        out_cnt--;
        if (out_cnt == 0) begin
          bus_a.imem_rvalid = 1'b1;
          bus_a.imem_rdata  = memf(out_addr);
          out_v = 1'b0;
        end
      end
      bus_a.imem_gnt = gnt_en;
      fire_prev = bus_a.imem_req && gnt_en;
      addr_prev = bus_a.imem_addr;
    end
  end

  // ---------------- scoreboard monitor for dut_a ----------------
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (bus_a.if_valid && bus_a.if_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected actual=pc %h instr %h required=no output", bus_a.if_pc, bus_a.if_instr);
        end else begin
          e = sb.pop_front();
          chk32("sb_instr", bus_a.if_instr, e.instr);
          chk32("sb_pc", bus_a.if_pc, e.pc);
          chk32("sb_pc_plus4", bus_a.if_pc_plus4, e.pc + 32'd4);
          chk32("sb_opcode", {25'b0, bus_a.opcode}, {25'b0, e.instr[6:0]});
          chk32("sb_funct3", {29'b0, bus_a.funct3}, {29'b0, e.instr[14:12]});
          chk1("sb_funct7b5", bus_a.funct7b5, e.instr[30]);
        end
      end
    end
  end

  // ---------------- dut_b: free-running fetch, wrap capture ----------------
  logic        fb = 1'b0;
  logic [31:0] ab = 32'h0;
  logic [31:0] capb [3];
  int          nb = 0;
  logic        gotb = 1'b0;
  logic [31:0] b_pc = 32'h0;
  logic [31:0] b_plus4 = 32'h0;

  initial begin
    bus_b.imem_gnt        = 1'b1;
    bus_b.if_ready        = 1'b1;
    bus_b.redirect        = 1'b0;
    bus_b.redirect_target = 32'h0;
    bus_b.imem_rvalid     = 1'b0;
    bus_b.imem_rdata      = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      bus_b.imem_rvalid = fb;
      bus_b.imem_rdata  = memf(ab);
      fb = bus_b.imem_req;
      ab = bus_b.imem_addr;
      if (bus_b.imem_req && nb < 3) begin
        capb[nb] = bus_b.imem_addr;
        nb++;
      end
      if (bus_b.if_valid && !gotb) begin
        gotb    = 1'b1;
        b_pc    = bus_b.if_pc;
        b_plus4 = bus_b.if_pc_plus4;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus_a.if_ready = 1'b0;
    bus_a.redirect = 1'b0;
    bus_a.redirect_target = 32'h0;
    repeat (3) @(negedge clk);

    chk1("rst_req", bus_a.imem_req, 1'b0);
    chk1("rst_valid", bus_a.if_valid, 1'b0);
    chk32("rst_instr", bus_a.if_instr, NOP);
    chk32("rst_if_pc", bus_a.if_pc, 32'h0);
    chk32("rst_opcode", {25'b0, bus_a.opcode}, 32'h13);

    // 1: first fetch after release
    rst_n = 1'b1;
    @(negedge clk);
    chk1("t1_req", bus_a.imem_req, 1'b1);
    chk32("t1_addr", bus_a.imem_addr, 32'h0);
    push(32'h0);
    @(negedge clk);
    chk1("t1_valid_early", bus_a.if_valid, 1'b0);
    @(negedge clk);
    chk1("t1_valid", bus_a.if_valid, 1'b1);
    chk32("t1_if_pc", bus_a.if_pc, 32'h0);
    chk32("t1_instr", bus_a.if_instr, 32'h0050_0093);
    chk32("t1_opcode", {25'b0, bus_a.opcode}, 32'h13);
    chk32("t1_funct3", {29'b0, bus_a.funct3}, 32'h0);
    chk32("t1_plus4", bus_a.if_pc_plus4, 32'h4);
    chk1("t1_req_idle", bus_a.imem_req, 1'b0);

    // 2: decode stall holds the buffer and blocks fetch
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("t2_req_stall", bus_a.imem_req, 1'b0);
      chk32("t2_instr_stable", bus_a.if_instr, 32'h0050_0093);
      chk32("t2_pc_stable", bus_a.if_pc, 32'h0);
    end
    bus_a.if_ready = 1'b1;
    @(negedge clk);
    bus_a.if_ready = 1'b0;
    chk1("t2_req", bus_a.imem_req, 1'b1);
    chk32("t2_addr", bus_a.imem_addr, 32'h4);
    chk1("t2_valid_clr", bus_a.if_valid, 1'b0);
    chk32("t2_nop", bus_a.if_instr, NOP);
    push(32'h4);
    wait_valid("t2_fill", 10);
    chk32("t2_if_pc", bus_a.if_pc, 32'h4);

    // 3: grant withheld, request held stable
    gnt_en = 1'b0;
    bus_a.if_ready = 1'b1;
    @(negedge clk);
    bus_a.if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk1("t3_req_held", bus_a.imem_req, 1'b1);
      chk32("t3_addr_held", bus_a.imem_addr, 32'h8);
      @(negedge clk);
    end
    gnt_en = 1'b1;
    push(32'h8);
    wait_valid("t3_fill", 10);
    chk32("t3_if_pc", bus_a.if_pc, 32'h8);

    // 4: redirect while waiting; pending response is dropped
    lat = 3;
    bus_a.if_ready = 1'b1;
    @(negedge clk);
    bus_a.if_ready = 1'b0;
    chk1("t4_req", bus_a.imem_req, 1'b1);
    chk32("t4_addr", bus_a.imem_addr, 32'hC);
    @(negedge clk);
    bus_a.redirect = 1'b1;
    bus_a.redirect_target = 32'h0000_0103;
    @(negedge clk);
    bus_a.redirect = 1'b0;
    chk1("t4_valid_kill", bus_a.if_valid, 1'b0);
    chk1("t4_req_wait", bus_a.imem_req, 1'b0);
    wait_req("t4_req_new", 12);
    chk32("t4_addr_new", bus_a.imem_addr, 32'h0000_0100);
    chk1("t4_valid_dropped", bus_a.if_valid, 1'b0);
    push(32'h100);
    wait_valid("t4_fill", 15);
    chk32("t4_if_pc", bus_a.if_pc, 32'h100);
    chk32("t4_instr", bus_a.if_instr, 32'h4100_5033);

    // redirect with same-cycle consume, then redirect in REQ without gnt
    lat = 1;
    gnt_en = 1'b0;
    bus_a.if_ready = 1'b1;
    bus_a.redirect = 1'b1;
    bus_a.redirect_target = 32'h0000_0202;
    @(negedge clk);
    bus_a.if_ready = 1'b0;
    bus_a.redirect = 1'b0;
    chk1("rd_valid_clr", bus_a.if_valid, 1'b0);
    chk1("rd_req", bus_a.imem_req, 1'b1);
    chk32("rd_addr", bus_a.imem_addr, 32'h200);
    bus_a.redirect = 1'b1;
    bus_a.redirect_target = 32'h0000_0300;
    @(negedge clk);
    bus_a.redirect = 1'b0;
    chk1("rd2_req", bus_a.imem_req, 1'b1);
    chk32("rd2_addr", bus_a.imem_addr, 32'h300);
    gnt_en = 1'b1;
    push(32'h300);
    wait_valid("rd2_fill", 10);
    chk32("rd2_if_pc", bus_a.if_pc, 32'h300);

    // 6: reset during WAIT, stray response afterwards ignored
    bus_a.if_ready = 1'b1;
    @(negedge clk);
    bus_a.if_ready = 1'b0;
    lat = 4;
    @(negedge clk);
    rst_n = 1'b0;
    gnt_en = 1'b0;
    #1;
    chk1("t6_req_rst", bus_a.imem_req, 1'b0);
    chk1("t6_valid_rst", bus_a.if_valid, 1'b0);
    chk32("t6_addr_rst", bus_a.imem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("t6_req", bus_a.imem_req, 1'b1);
      chk32("t6_addr", bus_a.imem_addr, 32'h0);
      chk1("t6_stray_ignored", bus_a.if_valid, 1'b0);
    end
    lat = 1;
    gnt_en = 1'b1;
    push(32'h0);
    wait_valid("t6_fill", 10);
    chk32("t6_if_pc", bus_a.if_pc, 32'h0);
    chk32("t6_instr", bus_a.if_instr, 32'h0050_0093);
    bus_a.if_ready = 1'b1;
    @(negedge clk);
    bus_a.if_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk32("sb_drained", sb.size(), 32'd0);

    // 5: PC wrap on the second instance
    chk32("t5_nreq", nb, 32'd3);
    chk32("t5_addr0", capb[0], 32'hFFFF_FFFC);
    chk32("t5_addr1", capb[1], 32'h0000_0000);
    chk32("t5_addr2", capb[2], 32'h0000_0004);
    chk1("t5_got", gotb, 1'b1);
    chk32("t5_if_pc", b_pc, 32'hFFFF_FFFC);
    chk32("t5_plus4_wrap", b_plus4, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
